// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-lite control unit: opcodes, functs,
// FSM state codes (FETCH=0), ALU codes, datapath mux encodings and the decode class.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Base 4-bit codes; the top widens them to its STATE_W.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_R_WB     = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_I_WB     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef struct packed {
    logic r;
    logic i;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic ill;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: one-hot class plus ALU op for the EXEC states.
// jal is a legal class only when MC_CTRL_JAL_EN is defined; otherwise it classifies as illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTL_W = 4
) (
  input  logic [31:0]          instr,
  output iclass_t              iclass,
  output logic [ALU_CTL_W-1:0] alu_ctl
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign fn          = instr[5:0];
  assign unused_bits = ^instr[25:6];

  always_comb begin
    iclass  = '0;
    alu_ctl = ALU_CTL_W'(ALU_ADD);
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU) begin
          iclass.r = 1'b1;
        end else if (fn == FN_SUBU) begin
          iclass.r = 1'b1;
          alu_ctl  = ALU_CTL_W'(ALU_SUB);
        end else begin
          iclass.ill = 1'b1;
        end
      end
      OP_ORI: begin
        iclass.i = 1'b1;
        alu_ctl  = ALU_CTL_W'(ALU_OR);
      end
      OP_LUI: begin
        iclass.i = 1'b1;
        alu_ctl  = ALU_CTL_W'(ALU_LUI);
      end
      OP_LW:  iclass.lw  = 1'b1;
      OP_SW:  iclass.sw  = 1'b1;
      OP_BEQ: iclass.beq = 1'b1;
      OP_J:   iclass.j   = 1'b1;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: iclass.jal = 1'b1;
`endif
      default: iclass.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite control FSM; memory states wait on mem_ready, TRAP holds until reset.
// Outputs are forced to 0 while rst_n is low. Optional jal support via MC_CTRL_JAL_EN.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTL_W = 4,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 alu_zero,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ext_zero,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state_o
);

  logic [STATE_W-1:0]   state;
  logic [STATE_W-1:0]   nxt;
  iclass_t              iclass;
  logic [ALU_CTL_W-1:0] dec_alu;

  mc_ctrl_decode #(.ALU_CTL_W(ALU_CTL_W)) u_decode (
    .instr   (instr),
    .iclass  (iclass),
    .alu_ctl (dec_alu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STATE_W'(S_FETCH);
    else        state <= nxt;
  end

  always_comb begin
    nxt = STATE_W'(S_FETCH);
    case (state)
      STATE_W'(S_FETCH):    nxt = mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
      STATE_W'(S_DECODE): begin
        if (iclass.r)                  nxt = STATE_W'(S_EXEC_R);
        else if (iclass.i)             nxt = STATE_W'(S_EXEC_I);
        else if (iclass.lw | iclass.sw) nxt = STATE_W'(S_MEM_ADDR);
        else if (iclass.beq)           nxt = STATE_W'(S_BRANCH);
        else if (iclass.j | iclass.jal) nxt = STATE_W'(S_JUMP);
        else                           nxt = STATE_W'(S_TRAP);
      end
      STATE_W'(S_EXEC_R):   nxt = STATE_W'(S_R_WB);
      STATE_W'(S_EXEC_I):   nxt = STATE_W'(S_I_WB);
      STATE_W'(S_MEM_ADDR): nxt = iclass.lw ? STATE_W'(S_MEM_RD) : STATE_W'(S_MEM_WR);
      STATE_W'(S_MEM_RD):   nxt = mem_ready ? STATE_W'(S_MEM_WB) : STATE_W'(S_MEM_RD);
      STATE_W'(S_MEM_WR):   nxt = mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEM_WR);
      STATE_W'(S_TRAP):     nxt = STATE_W'(S_TRAP);
      default:              nxt = STATE_W'(S_FETCH);
    endcase
  end

  // Everything stays 0 while reset is held, even though the state reads FETCH.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PCSRC_SEQ;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    ext_zero  = 1'b0;
    alu_ctl   = ALU_CTL_W'(ALU_ADD);
    reg_write = 1'b0;
    reg_dst   = RDST_RT;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;
    state_o   = '0;
    if (rst_n) begin
      state_o = state;
      case (state)
        STATE_W'(S_FETCH): begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_4;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        STATE_W'(S_DECODE): alu_src_b = SRCB_IMM_SH;
        STATE_W'(S_EXEC_R): begin
          alu_src_a = 1'b1;
          alu_ctl   = dec_alu;
        end
        STATE_W'(S_R_WB): begin
          reg_write = 1'b1;
          reg_dst   = RDST_RD;
        end
        STATE_W'(S_EXEC_I): begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          ext_zero  = 1'b1;
          alu_ctl   = dec_alu;
        end
        STATE_W'(S_I_WB): reg_write = 1'b1;
        STATE_W'(S_MEM_ADDR): begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        STATE_W'(S_MEM_RD): begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        STATE_W'(S_MEM_WB): begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
        end
        STATE_W'(S_MEM_WR): begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
        end
        STATE_W'(S_BRANCH): begin
          alu_src_a = 1'b1;
          alu_ctl   = ALU_CTL_W'(ALU_SUB);
          pc_src    = PCSRC_BR;
          pc_write  = alu_zero;
        end
        STATE_W'(S_JUMP): begin
          pc_write  = 1'b1;
          pc_src    = PCSRC_JMP;
          reg_write = iclass.jal;
          reg_dst   = iclass.jal ? RDST_RA : RDST_RT;
          wb_sel    = iclass.jal ? WB_PC : WB_ALU;
        end
        STATE_W'(S_TRAP): illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised instruction stream for mc_ctrl checked cycle by cycle against a phase-list model.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a, ext_zero;
  logic        reg_write, illegal;
  logic [1:0]  pc_src, alu_src_b, reg_dst, wb_sel;
  logic [3:0]  alu_ctl;
  logic [3:0]  state_o;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [3:0] alu_ctl;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       illegal;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, ext_zero, alu_ctl, reg_write, reg_dst, wb_sel, illegal};

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_JAL = 6, C_ILL = 7;

  int errors = 0;
  int checks = 0;

  mc_ctrl #(.ALU_CTL_W(4), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_ctl(alu_ctl), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int class_of(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    if (op == 6'h00) return (fn == 6'h21 || fn == 6'h23) ? C_R : C_ILL;
    if (op == 6'h0d || op == 6'h0f) return C_I;
    if (op == 6'h23) return C_LW;
    if (op == 6'h2b) return C_SW;
    if (op == 6'h04) return C_BEQ;
    if (op == 6'h02) return C_J;
`ifdef MC_CTRL_JAL_EN
    if (op == 6'h03) return C_JAL;
`endif
    return C_ILL;
  endfunction

  // Expected control word for one cycle in a given phase.
  function automatic outs_t exp_out(input logic [3:0] ph, input logic [31:0] ins,
                                    input logic mr, input logic az);
    outs_t o = '0;
    case (ph)
      S_FETCH:    begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      S_DECODE:   o.alu_src_b = 2'b11;
      S_EXEC_R:   begin o.alu_src_a = 1; o.alu_ctl = (ins[5:0] == 6'h23) ? 4'd1 : 4'd0; end
      S_R_WB:     begin o.reg_write = 1; o.reg_dst = 2'b01; end
      S_EXEC_I:   begin
        o.alu_src_a = 1; o.alu_src_b = 2'b10; o.ext_zero = 1;
        o.alu_ctl = (ins[31:26] == 6'h0f) ? 4'd4 : 4'd3;
      end
      S_I_WB:     o.reg_write = 1;
      S_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      S_MEM_RD:   begin o.mem_req = 1; o.i_or_d = 1; end
      S_MEM_WB:   begin o.reg_write = 1; o.wb_sel = 2'b01; end
      S_MEM_WR:   begin o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1; end
      S_BRANCH:   begin o.alu_src_a = 1; o.alu_ctl = 4'd1; o.pc_src = 2'b01; o.pc_write = az; end
      S_JUMP: begin
        o.pc_write = 1; o.pc_src = 2'b10;
        if (class_of(ins) == C_JAL) begin o.reg_write = 1; o.reg_dst = 2'b10; o.wb_sel = 2'b10; end
      end
      S_TRAP:     o.illegal = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic step(input logic [31:0] ins, input logic mr, input logic az, input logic [3:0] ph);
    @(negedge clk);
    instr = ins; mem_ready = mr; alu_zero = az;
    #1;
    check($sformatf("out ph%0d ins %h", ph, ins), 32'(dut_o), 32'(exp_out(ph, ins, mr, az)));
    check($sformatf("state ph%0d ins %h", ph, ins), 32'(state_o), 32'(ph));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check("reset outputs", 32'(dut_o), 32'd0);
    check("reset state", 32'(state_o), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic az);
    int c = class_of(ins);
    int cyc = 0;
    int base = 3;
    for (int k = 0; k < wf; k++) begin step(ins, 1'b0, 1'($urandom), S_FETCH); cyc++; end
    step(ins, 1'b1, 1'($urandom), S_FETCH);
    step(ins, 1'($urandom), 1'($urandom), S_DECODE);
    cyc += 2;
    case (c)
      C_R: begin step(ins, 1'($urandom), 1'($urandom), S_EXEC_R); step(ins, 1'($urandom), 1'($urandom), S_R_WB); cyc += 2; base = 4; end
      C_I: begin step(ins, 1'($urandom), 1'($urandom), S_EXEC_I); step(ins, 1'($urandom), 1'($urandom), S_I_WB); cyc += 2; base = 4; end
      C_LW: begin
        step(ins, 1'($urandom), 1'($urandom), S_MEM_ADDR);
        for (int k = 0; k < wm; k++) step(ins, 1'b0, 1'($urandom), S_MEM_RD);
        step(ins, 1'b1, 1'($urandom), S_MEM_RD);
        step(ins, 1'($urandom), 1'($urandom), S_MEM_WB);
        cyc += 3 + wm; base = 5 + wm;
      end
      C_SW: begin
        step(ins, 1'($urandom), 1'($urandom), S_MEM_ADDR);
        for (int k = 0; k < wm; k++) step(ins, 1'b0, 1'($urandom), S_MEM_WR);
        step(ins, 1'b1, 1'($urandom), S_MEM_WR);
        cyc += 2 + wm; base = 4 + wm;
      end
      C_BEQ: begin step(ins, 1'($urandom), az, S_BRANCH); cyc++; end
      C_J, C_JAL: begin step(ins, 1'($urandom), 1'($urandom), S_JUMP); cyc++; end
      default: begin
        for (int k = 0; k < 10; k++) step(ins, 1'($urandom), 1'($urandom), S_TRAP);
        do_reset();
        return;
      end
    endcase
    check($sformatf("latency ins %h", ins), 32'(cyc), 32'(base + wf));
  endtask

  function automatic logic [31:0] rand_instr(input int k);
    logic [31:0] r = $urandom;
    logic [5:0]  bad [6] = '{6'h01, 6'h05, 6'h08, 6'h0a, 6'h20, 6'h3f};
    case (k)
      0: return {6'h00, r[25:6], 6'h21};
      1: return {6'h00, r[25:6], 6'h23};
      2: return {6'h0d, r[25:0]};
      3: return {6'h0f, r[25:0]};
      4: return {6'h23, r[25:0]};
      5: return {6'h2b, r[25:0]};
      6: return {6'h04, r[25:0]};
      7: return {6'h02, r[25:0]};
      8: return {6'h03, r[25:0]};
      9: return {6'h00, r[25:6], 6'h20};
      default: return {bad[$urandom_range(0, 5)], r[25:0]};
    endcase
  endfunction

  initial begin
    do_reset();
    run_instr(32'h00221821, 0, 0, 1'b0);
    run_instr(32'h8C250004, 0, 2, 1'b0);
    run_instr(32'hAC250008, 0, 0, 1'b0);
    run_instr(32'h10220003, 0, 0, 1'b1);
    run_instr(32'h10220003, 0, 0, 1'b0);
    run_instr(32'hFC000000, 0, 0, 1'b0);
    run_instr(32'h0C000010, 0, 0, 1'b0);
    run_instr(32'h3C011234, 1, 0, 1'b0);
    run_instr(32'h00221823, 0, 0, 1'b0);

    // Reset while a store is waiting on memory.
    step(32'hAC250008, 1'b1, 1'b0, S_FETCH);
    step(32'hAC250008, 1'b0, 1'b0, S_DECODE);
    step(32'hAC250008, 1'b0, 1'b0, S_MEM_ADDR);
    step(32'hAC250008, 1'b0, 1'b0, S_MEM_WR);
    step(32'hAC250008, 1'b0, 1'b0, S_MEM_WR);
    do_reset();
    run_instr(32'h00221821, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++)
      run_instr(rand_instr($urandom_range(0, 10)), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
